// File: rtl/vec_mem_responder.sv
// Vector memory responder: serialises a LANES-wide M-stage request onto a single-port
// synchronous RAM (1-cycle read latency) and stalls the pipeline until the vector completes.
module vec_mem_responder #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 10,
  parameter int LANES  = 3,
  parameter int DEPTH  = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ReqValid,
  input  logic                     ReqWrite,
  input  logic [LANES*ADDR_W-1:0]  AddrM,
  input  logic [LANES*DATA_W-1:0]  WriteDataM,
  output logic [LANES*DATA_W-1:0]  RDM,
  output logic                     StallMem,
  output logic                     RespValid,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  output logic                     ram_we,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [LW-1:0]           lane_r, lane_d_r;
  logic                    rd_pending_r, in_range_d_r, write_q_r, resp_valid_r;
  logic [ADDR_W-1:0]       addr_q_r  [LANES];
  logic [DATA_W-1:0]       wdata_q_r [LANES];
  logic [LANES*DATA_W-1:0] rdm_r;
  logic [ADDR_W-1:0]       cur_addr_s;
  logic [DATA_W-1:0]       cur_wdata_s;
  logic                    in_range_s;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  // Current lane selection from the latched request
  always_comb begin
    cur_addr_s  = addr_q_r[lane_r];
    cur_wdata_s = wdata_q_r[lane_r];
    in_range_s  = addr_in_range(cur_addr_s);
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and RAM-side/stall decode
  always_comb begin
    state_s   = state_r;
    StallMem  = 1'b0;
    ram_addr  = {ADDR_W{1'b0}};
    ram_wdata = {DATA_W{1'b0}};
    ram_we    = 1'b0;
    case (state_r)
      IDLE: begin
        if (ReqValid) begin
          state_s  = ISSUE;
          StallMem = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        StallMem  = 1'b1;
        ram_addr  = cur_addr_s;
        ram_wdata = cur_wdata_s;
        ram_we    = write_q_r & in_range_s;
        if (lane_r == LAST_LANE) begin
          state_s = write_q_r ? DONE : WAIT;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT: begin
        StallMem = 1'b1;
        state_s  = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request latch, lane sequencing, read capture and response pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      lane_r       <= {LW{1'b0}};
      lane_d_r     <= {LW{1'b0}};
      rd_pending_r <= 1'b0;
      in_range_d_r <= 1'b0;
      write_q_r    <= 1'b0;
      resp_valid_r <= 1'b0;
      rdm_r        <= {(LANES*DATA_W){1'b0}};
      for (int i = 0; i < LANES; i++) begin
        addr_q_r[i]  <= {ADDR_W{1'b0}};
        wdata_q_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      resp_valid_r <= (state_s == DONE);
      if (state_r == IDLE && ReqValid) begin
        lane_r    <= {LW{1'b0}};
        write_q_r <= ReqWrite;
        for (int i = 0; i < LANES; i++) begin
          addr_q_r[i]  <= AddrM[i*ADDR_W +: ADDR_W];
          wdata_q_r[i] <= WriteDataM[i*DATA_W +: DATA_W];
        end
      end else if (state_r == ISSUE && lane_r != LAST_LANE) begin
        lane_r <= lane_r + {{(LW-1){1'b0}}, 1'b1};
      end else begin
        lane_r <= lane_r;
      end
      // Data for a read lane issued this cycle arrives on the next edge
      rd_pending_r <= (state_r == ISSUE) && !write_q_r;
      if (state_r == ISSUE) begin
        lane_d_r     <= lane_r;
        in_range_d_r <= in_range_s;
      end else begin
        lane_d_r     <= lane_d_r;
        in_range_d_r <= in_range_d_r;
      end
      if (rd_pending_r) begin
        for (int i = 0; i < LANES; i++) begin
          if (lane_d_r == LW'(i)) begin
            rdm_r[i*DATA_W +: DATA_W] <= in_range_d_r ? ram_rdata : {DATA_W{1'b0}};
          end
        end
      end
    end
  end

  assign RDM       = rdm_r;
  assign RespValid = resp_valid_r;

endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Memory-side responder for the Filter-GPU datapath's M-stage vector port.
- Accepts one 3-lane request per instruction: per-lane address plus per-lane write data, read or write.
- Serialises the lanes onto one single-port synchronous RAM with 1-cycle read latency.
- Holds the pipeline with StallMem until the access completes, then presents the assembled RDM vector.

Parameters:
DATA_W, 18, lane data width
ADDR_W, 10, lane address width
LANES, 3, lanes per request
DEPTH, 1024, valid RAM words; must satisfy DEPTH <= 2**ADDR_W

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
ReqValid  in  1  M-stage memory op present (MemWriteM or MemtoRegM); held stable while StallMem=1
ReqWrite  in  1  1=write, 0=read; sampled at accept only
AddrM  in  LANES x ADDR_W  lane addresses (lane0=A1M, lane1=A2M, lane2=A3M)
WriteDataM  in  LANES x DATA_W  lane write data
RDM  out  LANES x DATA_W  read vector, registered
StallMem  out  1  hold M stage and earlier stages
RespValid  out  1  one-cycle pulse when the request completes
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after the address is issued

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Lane counter lane (0..LANES-1). Registered lane_d and rd_pending track the capture slot.
- Reset (sync, RST=1 at edge):
  - state=IDLE, lane=0, rd_pending=0.
  - RDM = all zero, RespValid=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - RST overrides any in-flight request. The partial request is abandoned, RDM is not updated, and no RespValid is produced.
- IDLE:
  - If ReqValid=1: latch AddrM, WriteDataM and ReqWrite into internal registers; next state ISSUE with lane=0.
  - Otherwise remain in IDLE.
- ISSUE (one cycle per lane):
  - ram_addr = addr_q[lane].
  - ram_we = write_q & in_range. in_range = addr_q[lane] < DEPTH.
  - ram_wdata = wdata_q[lane].
  - For reads: rd_pending<=1, lane_d<=lane.
  - If lane == LANES-1: next state is WAIT for reads, DONE for writes. Otherwise lane++.
- WAIT (reads only): capture of the final lane occurs here; next state DONE.
- Read capture: on any edge where rd_pending=1, RDM[lane_d] <= (lane_d address was in_range) ? ram_rdata : 0. rd_pending clears after the last lane is captured.
- DONE:
  - RespValid=1 and StallMem=0 for exactly one cycle; next state IDLE.
  - ReqValid in this cycle belongs to the request being released and is NOT accepted.
- StallMem (combinational) = (state==IDLE & ReqValid) | state==ISSUE | state==WAIT.
- Timing, with the request first seen in IDLE at cycle T:
  - Read: ISSUE T+1..T+3, WAIT T+4, DONE T+5. StallMem high T..T+4. RDM fully valid from T+5.
  - Write: ISSUE T+1..T+3, DONE T+4. StallMem high T..T+3.
  - Back-to-back requests: next accept no earlier than T+6 (read) or T+5 (write).
- RDM holds its last value across writes and idle cycles. Only completed read lanes update RDM.
- ram_we=0 in every state other than ISSUE.
- Addresses are used as given. Wrap of A1M±1 (e.g. 0-1=1023) is the requester's arithmetic; the block performs no correction.
- Out-of-range lane (addr >= DEPTH):
  - Write is suppressed.
  - Read returns 0.
  - Timing is unchanged.
- Duplicate addresses within one write request: lanes are written in order 0,1,2, so the highest lane wins.
- Input changes while StallMem=1 are ignored; latched copies are used.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, ReqValid=0 -> RDM=0, StallMem=0, RespValid=0, ram_we=0 throughout.
- Write request AddrM={12,13,11}, data {18'h00AAA,18'h00BBB,18'h00CCC} at T -> ram_we=1 at T+1..T+3 with addr 12,13,11 in order; StallMem high T..T+3; RespValid pulse at T+4.
- Read of the same addresses at T -> StallMem high T..T+4; RespValid at T+5 with RDM={00AAA,00BBB,00CCC}; ReqValid still high at T+5 is not re-accepted; IDLE at T+6.
- Wrap and range, DEPTH=1000: read AddrM={0,1,1023} -> lane2 returns 0; write of the same request leaves RAM word 1023 untouched.
- Reset mid-read: RST at T+2 of a read -> next cycle IDLE, StallMem=0, RDM=0, no RespValid; a fresh read afterwards completes normally in 6 cycles.
- Duplicate write AddrM={5,5,5}, data {1,2,3} followed by a read of 5 -> RDM={3,3,3}.
